// File: rtl/fetch_predict_stage.sv
// Instruction fetch stage: issues in-order bus requests along a predicted path
// (optional direct-mapped BTB), queues responses for decode, recovers on commit.

module fetch_predict_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head = mem[rd_ptr];

  // NOTE: storage is not reset; pointers and count are, so stale words are never presented as valid.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule

module fetch_predict_stage #(
  parameter logic [31:0] RST_INST_ADDR = 32'h0,
  parameter int          HIST_DEPTH    = 4,
  parameter int          OUTQ_DEPTH    = 2,
  parameter int          BTB_ENTRIES   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_next_pc,
  output logic        pred_miss,
  output logic [31:0] inst_addr,
  output logic        inst_avalid,
  input  logic        inst_aready,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pred_npc
);
  localparam int QCW = $clog2(OUTQ_DEPTH + 1);
  localparam int HCW = $clog2(HIST_DEPTH + 1);

  logic [31:0]    fetch_pc;
  logic [31:0]    pred_npc;
  logic [QCW-1:0] pend_cnt;
  logic [QCW-1:0] outq_cnt;
  logic [QCW-1:0] disc_cnt;
  logic [HCW-1:0] hist_cnt;
  logic [63:0]    pend_head;
  logic [63:0]    hist_head;
  logic [95:0]    outq_head;
  logic [31:0]    inflight;
  logic [31:0]    occupancy;
  logic           hist_nonempty;
  logic           hist_pop;
  logic           req_fire;
  logic           rsp_keep;
  logic           out_fire;

  // inflight bounds bus requests (stale ones included); occupancy bounds the replay window.
  assign inflight      = 32'(pend_cnt) + 32'(outq_cnt) + 32'(disc_cnt);
  assign occupancy     = 32'(pend_cnt) + 32'(outq_cnt) + 32'(hist_cnt);
  assign hist_nonempty = (hist_cnt != '0);

  assign pred_miss   = !rst && commit_valid && hist_nonempty && (commit_next_pc != hist_head[31:0]);
  assign hist_pop    = !rst && commit_valid && hist_nonempty && !pred_miss;
  assign inst_addr   = fetch_pc;
  assign inst_avalid = !rst && !pred_miss && (inflight < 32'(OUTQ_DEPTH))
                       && (occupancy < 32'(HIST_DEPTH));
  assign req_fire    = inst_avalid && inst_aready;
  assign rsp_keep    = !rst && inst_rvalid && (disc_cnt == '0);

  assign out_valid = !rst && (outq_cnt != '0) && !pred_miss;
  assign {out_inst, out_pc, out_pred_npc} = outq_head;
  assign out_fire  = out_valid && out_ready;

  fetch_predict_fifo #(.W(64), .DEPTH(OUTQ_DEPTH)) u_pend (
    .clk(clk), .rst(rst), .clr(pred_miss),
    .push(req_fire), .push_data({fetch_pc, pred_npc}),
    .pop(rsp_keep), .head(pend_head), .count(pend_cnt)
  );

  fetch_predict_fifo #(.W(96), .DEPTH(OUTQ_DEPTH)) u_outq (
    .clk(clk), .rst(rst), .clr(pred_miss),
    .push(rsp_keep), .push_data({inst_rdata, pend_head}),
    .pop(out_fire), .head(outq_head), .count(outq_cnt)
  );

  fetch_predict_fifo #(.W(64), .DEPTH(HIST_DEPTH)) u_hist (
    .clk(clk), .rst(rst), .clr(pred_miss),
    .push(out_fire), .push_data({out_pc, out_pred_npc}),
    .pop(hist_pop), .head(hist_head), .count(hist_cnt)
  );

  // Responses to requests flushed by a miss still arrive; disc_cnt counts them out.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RST_INST_ADDR;
      disc_cnt <= '0;
    end else if (pred_miss) begin
      fetch_pc <= commit_next_pc;
      disc_cnt <= disc_cnt + pend_cnt - QCW'(inst_rvalid);
    end else begin
      if (req_fire) fetch_pc <= pred_npc;
      if (inst_rvalid && (disc_cnt != '0)) disc_cnt <= disc_cnt - QCW'(1);
    end
  end

  generate
    if (BTB_ENTRIES > 0) begin : g_btb
      localparam int IDXW = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 0;
      localparam int IW   = (IDXW > 0) ? IDXW : 1;
      localparam int TAGW = 30 - IDXW;

      logic [BTB_ENTRIES-1:0] btb_valid;
      logic [TAGW-1:0]        btb_tag [BTB_ENTRIES];
      logic [31:0]            btb_tgt [BTB_ENTRIES];
      logic [IW-1:0]          look_idx;
      logic [IW-1:0]          upd_idx;
      logic [TAGW-1:0]        look_tag;
      logic [TAGW-1:0]        upd_tag;
      logic [31:0]            upd_pc;
      logic                   upd_fallthru;

      function automatic logic [IW-1:0] idx_of(input logic [31:0] pc);
        return (IDXW == 0) ? '0 : IW'(pc >> 2);
      endfunction

      function automatic logic [TAGW-1:0] tag_of(input logic [31:0] pc);
        return TAGW'(pc >> (IDXW + 2));
      endfunction

      assign upd_pc       = hist_head[63:32];
      assign look_idx     = idx_of(fetch_pc);
      assign look_tag     = tag_of(fetch_pc);
      assign upd_idx      = idx_of(upd_pc);
      assign upd_tag      = tag_of(upd_pc);
      assign upd_fallthru = (commit_next_pc == upd_pc + 32'd4);

      // NOTE: default assignment first so every path drives pred_npc and no latch is inferred.
      always_comb begin
        pred_npc = fetch_pc + 32'd4;
        if (btb_valid[look_idx] && (btb_tag[look_idx] == look_tag)) pred_npc = btb_tgt[look_idx];
      end

      // A miss to the fall-through PC means the branch was not taken: forget it.
      always_ff @(posedge clk) begin
        if (rst) begin
          btb_valid <= '0;
        end else if (pred_miss) begin
          if (!upd_fallthru)                     btb_valid[upd_idx] <= 1'b1;
          else if (btb_tag[upd_idx] == upd_tag)  btb_valid[upd_idx] <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (pred_miss && !upd_fallthru) begin
          btb_tag[upd_idx] <= upd_tag;
          btb_tgt[upd_idx] <= commit_next_pc;
        end
      end
    end else begin : g_no_btb
      logic btb_unused;
      assign btb_unused = ^hist_head[63:32];
      assign pred_npc   = fetch_pc + 32'd4;
    end
  endgenerate
endmodule

// File: tb/tb_fetch_predict_stage.sv
// Bench for fetch_predict_stage: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a queue-based reference model.

module tb_fetch_predict_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_next_pc;
  logic        pred_miss;
  logic [31:0] inst_addr;
  logic        inst_avalid;
  logic        inst_aready;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pred_npc;

  fetch_predict_stage #(
    .RST_INST_ADDR(32'h0), .HIST_DEPTH(4), .OUTQ_DEPTH(2), .BTB_ENTRIES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_next_pc(commit_next_pc),
    .pred_miss(pred_miss),
    .inst_addr(inst_addr), .inst_avalid(inst_avalid), .inst_aready(inst_aready),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pred_npc(out_pred_npc)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_cnt  = 0;
  int          hs_cnt   = 0;
  bit          rsp_en   = 1'b0;
  logic [31:0] bus_q [$];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst;
  } ent_t;

  ent_t        m_pend [$];
  ent_t        m_outq [$];
  ent_t        m_hist [$];
  logic [31:0] m_fetch;
  int          m_disc;
  bit          m_bv   [8];
  logic [31:0] m_btag [8];
  logic [31:0] m_btgt [8];

  typedef struct {
    bit          aready;
    bit          rsp;
    bit          oready;
    bit          cv;
    logic [31:0] cnpc;
    bit          e_avalid;
    logic [31:0] e_addr;
    bit          e_ovalid;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Bus responder: answers the oldest outstanding request when enabled.
  task automatic settle();
    inst_rvalid = rsp_en && (bus_q.size() > 0);
    inst_rdata  = inst_rvalid ? mem_word(bus_q[0]) : 32'h0;
    #1;
  endtask

  task automatic step();
    bit          acc;
    bit          rv;
    bit          hs;
    logic [31:0] a;
    acc = inst_avalid && inst_aready;
    rv  = inst_rvalid;
    hs  = out_valid && out_ready;
    a   = inst_addr;
    @(posedge clk);
    if (rst) begin
      bus_q.delete();
    end else begin
      if (rv && bus_q.size() > 0) void'(bus_q.pop_front());
      if (acc) begin bus_q.push_back(a); acc_cnt++; end
      if (hs) hs_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; commit_valid = 1'b0; commit_next_pc = 32'h0;
    inst_aready = 1'b0; out_ready = 1'b0; rsp_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rst_avalid", inst_avalid, 1'b0);
      check("rst_ovalid", out_valid, 1'b0);
      check("rst_miss", pred_miss, 1'b0);
      step();
    end
    rst = 1'b0;
    acc_cnt = 0;
    hs_cnt  = 0;
  endtask

  // Wait for the first delivered instruction, then commit tgt against it.
  task automatic redirect(input logic [31:0] tgt, output logic [31:0] hpc, output logic [31:0] hnpc);
    bit seen;
    seen = 1'b0; hpc = 32'hx; hnpc = 32'hx;
    inst_aready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1; commit_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      settle();
      if (out_valid) begin seen = 1'b1; hpc = out_pc; hnpc = out_pred_npc; end
      step();
    end
    if (!seen) timeout("redirect_wait");
    commit_valid = 1'b1; commit_next_pc = tgt;
    settle();
    check("redirect_miss", pred_miss, 1'b1);
    step();
    commit_valid = 1'b0;
  endtask

  function automatic logic [31:0] m_npc(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & 32'h7);
    if (m_bv[i] && m_btag[i] == (pc >> 5)) return m_btgt[i];
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pick_cnpc();
    if (m_hist.size() > 0 && $urandom_range(0, 2) != 0) return m_hist[0].npc;
    case ($urandom_range(0, 3))
      0:       return 32'h10;
      1:       return 32'h40;
      2:       return 32'h100;
      default: return (m_hist.size() > 0) ? m_hist[0].pc + 32'd4 : 32'h14;
    endcase
  endfunction

  task automatic m_update(input bit e_miss, input bit e_avalid, input bit e_ovalid);
    ent_t        e;
    logic [31:0] npc;
    int          i;
    if (rst) begin
      m_pend.delete(); m_outq.delete(); m_hist.delete();
      m_fetch = 32'h0; m_disc = 0;
      foreach (m_bv[k]) m_bv[k] = 1'b0;
      return;
    end
    npc = m_npc(m_fetch);
    if (e_miss) begin
      e = m_hist[0];
      i = int'((e.pc >> 2) & 32'h7);
      if (commit_next_pc == e.pc + 32'd4) begin
        if (m_bv[i] && m_btag[i] == (e.pc >> 5)) m_bv[i] = 1'b0;
      end else begin
        m_bv[i] = 1'b1; m_btag[i] = e.pc >> 5; m_btgt[i] = commit_next_pc;
      end
      m_disc = m_disc + m_pend.size() - (inst_rvalid ? 1 : 0);
      m_pend.delete(); m_outq.delete(); m_hist.delete();
      m_fetch = commit_next_pc;
    end else begin
      if (commit_valid && m_hist.size() > 0) void'(m_hist.pop_front());
      if (e_ovalid && out_ready) m_hist.push_back(m_outq.pop_front());
      if (inst_rvalid) begin
        if (m_disc > 0) m_disc--;
        else if (m_pend.size() > 0) begin
          e = m_pend.pop_front(); e.inst = inst_rdata; m_outq.push_back(e);
        end
      end
      if (e_avalid && inst_aready) begin
        e.pc = m_fetch; e.npc = npc; e.inst = 32'h0;
        m_pend.push_back(e);
        m_fetch = npc;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vt [5];
    logic [31:0] first_addr;
    logic [31:0] hpc;
    logic [31:0] hnpc;
    bit          got;
    bit          e_miss;
    bit          e_avalid;
    bit          e_ovalid;

    // Reset release, back-to-back fetch, commit ignored while history is empty.
    vt[0] = '{1, 1, 1, 1, 32'hDEAD_BEE0, 1, 32'h0, 0, 32'h0, 32'h0, 32'h0};
    vt[1] = '{1, 1, 1, 1, 32'h0000_0100, 1, 32'h4, 0, 32'h0, 32'h0, 32'h0};
    vt[2] = '{1, 1, 1, 0, 32'h0,         0, 32'h8, 1, 32'h0, 32'h4, mem_word(32'h0)};
    vt[3] = '{1, 1, 1, 0, 32'h0,         1, 32'h8, 1, 32'h4, 32'h8, mem_word(32'h4)};
    vt[4] = '{1, 1, 1, 0, 32'h0,         1, 32'hC, 0, 32'h0, 32'h0, 32'h0};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      inst_aready = vt[i].aready; rsp_en = vt[i].rsp; out_ready = vt[i].oready;
      commit_valid = vt[i].cv; commit_next_pc = vt[i].cnpc;
      settle();
      check($sformatf("vec%0d_avalid", i), inst_avalid, vt[i].e_avalid);
      check($sformatf("vec%0d_addr", i), inst_addr, vt[i].e_addr);
      check($sformatf("vec%0d_ovalid", i), out_valid, vt[i].e_ovalid);
      check($sformatf("vec%0d_miss", i), pred_miss, 1'b0);
      if (vt[i].e_ovalid) begin
        check($sformatf("vec%0d_pc", i), out_pc, vt[i].e_pc);
        check($sformatf("vec%0d_npc", i), out_pred_npc, vt[i].e_npc);
        check($sformatf("vec%0d_inst", i), out_inst, vt[i].e_inst);
      end
      step();
    end
    commit_valid = 1'b0;

    // Decode backpressure: only the output queue depth worth of requests.
    do_reset();
    inst_aready = 1'b1; rsp_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin settle(); step(); end
    check("bp_accepts", acc_cnt, 2);
    settle();
    check("bp_avalid_low", inst_avalid, 1'b0);
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      settle();
      if (inst_avalid) got = 1'b1;
      else step();
    end
    check("bp_resume", got, 1'b1);

    // History full: four deliveries, then one commit frees exactly one slot.
    do_reset();
    inst_aready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin settle(); step(); end
    check("hist_handshakes", hs_cnt, 4);
    check("hist_accepts", acc_cnt, 4);
    settle();
    check("hist_avalid_low", inst_avalid, 1'b0);
    commit_valid = 1'b1; commit_next_pc = 32'h4;
    settle();
    check("hist_commit_nomiss", pred_miss, 1'b0);
    step();
    commit_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin settle(); step(); end
    check("hist_one_more", acc_cnt, 5);

    // Mispredict with two requests outstanding.
    do_reset();
    inst_aready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin settle(); step(); end
    rsp_en = 1'b0; commit_valid = 1'b1; commit_next_pc = 32'h4;
    settle();
    check("mp_first_commit", pred_miss, 1'b0);
    step();
    commit_next_pc = 32'h100;
    settle();
    check("mp_miss", pred_miss, 1'b1);
    check("mp_avalid", inst_avalid, 1'b0);
    check("mp_ovalid", out_valid, 1'b0);
    check("mp_outstanding", bus_q.size(), 2);
    step();
    commit_valid = 1'b0; rsp_en = 1'b1;
    first_addr = 32'hFFFF_FFFF;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      settle();
      if (inst_avalid && inst_aready && first_addr == 32'hFFFF_FFFF) first_addr = inst_addr;
      if (out_valid) begin
        got = 1'b1;
        check("mp_out_pc", out_pc, 32'h100);
        check("mp_out_inst", out_inst, mem_word(32'h100));
        check("mp_out_npc", out_pred_npc, 32'h104);
      end
      step();
    end
    if (!got) timeout("mp_refill");
    check("mp_first_addr", first_addr, 32'h100);

    // BTB learns a taken branch at 0x10, then forgets it.
    do_reset();
    redirect(32'h10, hpc, hnpc);
    check("btb_r1_pc", hpc, 32'h0);
    redirect(32'h40, hpc, hnpc);
    check("btb_r2_pc", hpc, 32'h10);
    check("btb_r2_npc", hnpc, 32'h14);
    redirect(32'h10, hpc, hnpc);
    check("btb_r3_npc", hnpc, 32'h44);
    redirect(32'h14, hpc, hnpc);
    check("btb_learn_pc", hpc, 32'h10);
    check("btb_learn_npc", hnpc, 32'h40);
    redirect(32'h10, hpc, hnpc);
    check("btb_r5_npc", hnpc, 32'h18);
    redirect(32'h100, hpc, hnpc);
    check("btb_forget_pc", hpc, 32'h10);
    check("btb_forget_npc", hnpc, 32'h14);

    // Randomized traffic, including mid-run resets, against the reference model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst            = (cyc < 2) || ($urandom_range(0, 399) == 0);
      inst_aready    = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      rsp_en         = ($urandom_range(0, 9) < 7);
      commit_valid   = ($urandom_range(0, 2) == 0);
      commit_next_pc = pick_cnpc();
      settle();
      e_miss   = !rst && commit_valid && (m_hist.size() > 0) && (commit_next_pc != m_hist[0].npc);
      e_avalid = !rst && !e_miss && (m_pend.size() + m_outq.size() + m_disc < 2)
                 && (m_pend.size() + m_outq.size() + m_hist.size() < 4);
      e_ovalid = !rst && (m_outq.size() > 0) && !e_miss;
      check("rnd_miss", pred_miss, e_miss);
      check("rnd_avalid", inst_avalid, e_avalid);
      check("rnd_ovalid", out_valid, e_ovalid);
      if (!rst) check("rnd_addr", inst_addr, m_fetch);
      if (e_ovalid) begin
        check("rnd_pc", out_pc, m_outq[0].pc);
        check("rnd_npc", out_pred_npc, m_outq[0].npc);
        check("rnd_inst", out_inst, m_outq[0].inst);
      end
      m_update(e_miss, e_avalid, e_ovalid);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
